// File: rtl/csi_tx_packetizer.sv
// Two-lane CSI-2 HS packet transmitter: sync, header+ECC, payload, CRC-16 footer, LP gap.
// Outputs are registered from the current state, so hs_data lags the state register by one cycle.
module csi_tx_packetizer #(
  parameter int HS_PREP = 4,
  parameter int LP_GAP  = 16
) (
  input  logic        word_clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_vc,
  input  logic [5:0]  cmd_dt,
  input  logic [15:0] cmd_wc,
  input  logic [15:0] pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic        hs_en,
  output logic        hs_valid,
  output logic [15:0] hs_data,
  output logic        underrun,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, PREP, SYNC, HDR0, HDR1, PAYLOAD, CRC, GAP} state_t;

  state_t      state, state_nxt;
  logic [15:0] cnt;
  logic [1:0]  vc_q;
  logic [5:0]  dt_q;
  logic [15:0] wc_q;
  logic [15:0] crc;
  logic        accept, is_long;
  logic [15:0] pay_word, hdr0_word, hdr1_word, words_last;

  function automatic logic [5:0] hdr_ecc(input logic [23:0] d);
    logic [5:0] p;
    p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
    p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
    p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
    p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
    p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
    p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
    return p;
  endfunction

  // Reflected CRC-16 (poly 0x1021 bit-reversed = 0x8408), one byte LSB-first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {8'h00, b};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 16'h8408) : (r >> 1);
    end
    return r;
  endfunction

  assign cmd_ready  = (state == IDLE);
  assign pix_ready  = (state == PAYLOAD);
  assign busy       = (state != IDLE);
  assign accept     = cmd_valid && cmd_ready;
  assign is_long    = (dt_q >= 6'h10);
  assign pay_word   = pix_valid ? pix_data : 16'h0000;
  assign hdr0_word  = {wc_q[7:0], vc_q, dt_q};
  assign hdr1_word  = {2'b00, hdr_ecc({wc_q, vc_q, dt_q}), wc_q[15:8]};
  assign words_last = {1'b0, wc_q[15:1]} - 16'd1;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = (HS_PREP > 1) ? PREP : SYNC;
      PREP:    if (cnt == 16'(HS_PREP - 2)) state_nxt = SYNC;
      SYNC:    state_nxt = HDR0;
      HDR0:    state_nxt = HDR1;
      HDR1: begin
        if (!is_long)            state_nxt = GAP;
        else if (wc_q == 16'd0)  state_nxt = CRC;
        else                     state_nxt = PAYLOAD;
      end
      PAYLOAD: if (cnt == words_last) state_nxt = CRC;
      CRC:     state_nxt = GAP;
      // One GAP cycle overlaps the last HS output word, hence LP_GAP+1 cycles here.
      GAP:     if (cnt == 16'(LP_GAP)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge word_clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 16'd0;
    end else begin
      state <= state_nxt;
      cnt   <= (state_nxt != state) ? 16'd0 : cnt + 16'd1;
    end
  end

  always_ff @(posedge word_clk) begin
    if (reset) begin
      vc_q <= 2'd0;
      dt_q <= 6'd0;
      wc_q <= 16'd0;
      crc  <= 16'hFFFF;
    end else begin
      if (accept) begin
        vc_q <= cmd_vc;
        dt_q <= cmd_dt;
        wc_q <= (cmd_dt >= 6'h10) ? {cmd_wc[15:1], 1'b0} : cmd_wc;
      end
      if (state == HDR1)
        crc <= 16'hFFFF;
      else if (state == PAYLOAD)
        crc <= crc16_byte(crc16_byte(crc, pay_word[7:0]), pay_word[15:8]);
    end
  end

  always_ff @(posedge word_clk) begin
    if (reset) begin
      hs_en    <= 1'b0;
      hs_valid <= 1'b0;
      hs_data  <= 16'h0000;
      underrun <= 1'b0;
    end else begin
      hs_en    <= 1'b0;
      hs_valid <= 1'b0;
      hs_data  <= 16'h0000;
      underrun <= 1'b0;
      unique case (state)
        IDLE: hs_en <= accept;
        PREP: hs_en <= 1'b1;
        SYNC: begin hs_en <= 1'b1; hs_valid <= 1'b1; hs_data <= 16'hB8B8;   end
        HDR0: begin hs_en <= 1'b1; hs_valid <= 1'b1; hs_data <= hdr0_word; end
        HDR1: begin hs_en <= 1'b1; hs_valid <= 1'b1; hs_data <= hdr1_word; end
        PAYLOAD: begin
          hs_en    <= 1'b1;
          hs_valid <= 1'b1;
          hs_data  <= pay_word;
          underrun <= !pix_valid;
        end
        CRC:  begin hs_en <= 1'b1; hs_valid <= 1'b1; hs_data <= crc; end
        default: ;
      endcase
    end
  end

endmodule
